long_divider: RTL and testbench



---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 22 ++
 rtl/long_divider.sv | 127 ++++++++++++
 tb/tb_long_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider and the exponentiator it feeds.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] dvs_ext;

  // The extra top bit keeps the shifted value exact even when the divisor MSB is set.
  assign p_shift = {p_i[WIDTH-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};
  assign q_o     = (p_shift >= dvs_ext);
  assign p_o     = q_o ? (p_shift - dvs_ext) : p_shift;

endmodule

// File: rtl/long_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/end pulse handshake shared with the modular exponentiator.
module long_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_end,
  output logic             div_busy,
  output logic             div_err,
  output div_state_e       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: div_start is a one-cycle request honoured only in IDLE; the
  // result is valid during the single cycle div_end is high and is held after.
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   step_p;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i       (p_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_o       (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    end_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          p_d     = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          err_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          err_d   = 1'b1;
          end_d   = 1'b1;
          state_d = DONE;
        end else begin
          // The dividend register doubles as the quotient shift register.
          p_d   = step_p;
          dvd_d = {dvd_q[WIDTH-2:0], step_bit};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quo_d   = {dvd_q[WIDTH-2:0], step_bit};
            rem_d   = step_p[WIDTH-1:0];
            end_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_end     = end_q;
  assign div_busy    = busy_q;
  assign div_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_long_divider.sv
// Directed bench for long_divider: hand-computed quotients, latency, error,
// ignored-start and mid-operation reset cases.
module tb_long_divider;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_end;
  logic         div_busy;
  logic         div_err;
  div_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  long_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_end     (div_end),
    .div_busy    (div_busy),
    .div_err     (div_err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one clock; returns just after the sampling edge E.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
  endtask

  // Count edges after E until div_end is seen; -1 on timeout.
  task automatic wait_end(input int already, output int lat);
    lat = already;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (div_end) return;
    end
    lat = -1;
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ee, input int elat);
    int lat;
    issue(a, b);
    check({tag, "_err_cleared"}, W'(div_err), W'(1'b0));
    wait_end(0, lat);
    check({tag, "_latency"}, W'(lat), W'(elat));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_err"}, W'(div_err), W'(ee));
    @(posedge clk);
    #1;
    check({tag, "_end_one_cycle"}, W'(div_end), W'(1'b0));
    check({tag, "_busy_low"}, W'(div_busy), W'(1'b0));
    check({tag, "_err_held"}, W'(div_err), W'(ee));
  endtask

  initial begin
    int lat;
    int end_seen;
    rst       = 1'b1;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_end", W'(div_end), '0);
    check("rst_busy", W'(div_busy), '0);
    check("rst_err", W'(div_err), '0);
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    repeat (5) @(posedge clk);
    #1;
    check("idle_hold_quotient", quotient, 32'd14);
    check("idle_hold_remainder", remainder, 32'd2);

    run_div("msb_div", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 32);
    run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
    run_div("div_by1", 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 32);
    run_div("div_by0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_div("after_err", 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 32);

    // A second start while busy must be dropped.
    issue(32'd1000, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend  = 32'd50;
    divisor   = 32'd5;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    check("ignore_busy", W'(div_busy), W'(1'b1));
    wait_end(10, lat);
    check("ignore_latency", W'(lat), W'(32));
    check("ignore_quotient", quotient, 32'd111);
    check("ignore_remainder", remainder, 32'd1);

    // Reset mid-operation aborts with no completion pulse.
    issue(32'd1000, 32'd9);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_busy", W'(div_busy), '0);
    check("abort_end", W'(div_end), '0);
    check("abort_state", W'(dbg_state), W'(IDLE));
    end_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end) end_seen++;
    end
    check("abort_no_end", W'(end_seen), '0);

    // Start coincident with reset is dropped.
    @(negedge clk);
    dividend  = 32'd40;
    divisor   = 32'd3;
    div_start = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    rst       = 1'b0;
    check("rst_wins_busy", W'(div_busy), '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wins_state", W'(dbg_state), W'(IDLE));

    run_div("d20_6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
